// File: rtl/dummy_dcm_diff_input_pkg.sv
// dummy_dcm_diff_input_pkg: shared defaults for the pass-through DCM stand-in
package dummy_dcm_diff_input_pkg;

    localparam int LOCK_COUNTER_WIDTH_DEFAULT = 8;
    localparam int HEARTBEAT_WIDTH            = 24;
    localparam int HEARTBEAT_BIT_DEFAULT      = 23;

endpackage

// File: rtl/dummy_dcm_diff_input_clock_lock_qualifier.sv
// clock_lock_qualifier: saturating count-up after reset release, registered locked flag
module clock_lock_qualifier #(
    parameter int LOCK_COUNTER_WIDTH = dummy_dcm_diff_input_pkg::LOCK_COUNTER_WIDTH_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          locked,
    output logic [LOCK_COUNTER_WIDTH-1:0] count
);

    localparam logic [LOCK_COUNTER_WIDTH-1:0] ALL_ONES = '1;

    // count up to all-ones and hold; locked follows one cycle after saturation and sticks
    always_ff @(posedge clock) begin
        if (!reset) begin
            count  <= '0;
            locked <= 1'b0;
        end else begin
            count  <= (count == ALL_ONES) ? count : count + 1'b1;
            locked <= locked | (count == ALL_ONES);
        end
    end

endmodule

// File: rtl/dummy_dcm_diff_input.sv
// dummy_dcm_diff_input: differential clock in, global clock out, qualified lock flag
// Optional heartbeat LED output when DUMMY_DCM_DIFF_INPUT_HEARTBEAT_EN is defined.
// Vendor IBUFGDS/BUFG are used when DUMMY_DCM_DIFF_INPUT_VENDOR_PRIMS is defined.
module dummy_dcm_diff_input
    import dummy_dcm_diff_input_pkg::*;
#(
    parameter int  LOCK_COUNTER_WIDTH = LOCK_COUNTER_WIDTH_DEFAULT,
    parameter real PERIOD             = 10.0,
    parameter int  HEARTBEAT_BIT      = HEARTBEAT_BIT_DEFAULT
) (
    input  logic                          clock_p,
    input  logic                          clock_n,
    input  logic                          reset,
    output logic                          clock_out,
`ifdef DUMMY_DCM_DIFF_INPUT_HEARTBEAT_EN
    output logic                          heartbeat,
`endif
    output logic                          clock_locked,
    output logic [LOCK_COUNTER_WIDTH-1:0] lock_count
);

    // PERIOD is a constraint annotation only; reject nonsense values at elaboration
    if (PERIOD <= 0.0) begin : g_bad_period
        $error("PERIOD must be positive");
    end
    if (HEARTBEAT_BIT < 0 || HEARTBEAT_BIT >= HEARTBEAT_WIDTH) begin : g_bad_hb_bit
        $error("HEARTBEAT_BIT out of range");
    end

    logic ibuf_clock;

`ifdef DUMMY_DCM_DIFF_INPUT_VENDOR_PRIMS
    IBUFGDS u_ibufgds (.I(clock_p), .IB(clock_n), .O(ibuf_clock));
    BUFG    u_bufg    (.I(ibuf_clock), .O(clock_out));
`else
    // differential receiver: follow the positive leg while legs differ, hold otherwise
    always_latch begin
        if (clock_p != clock_n) ibuf_clock = clock_p;
    end
    assign clock_out = ibuf_clock;
`endif

    clock_lock_qualifier #(
        .LOCK_COUNTER_WIDTH(LOCK_COUNTER_WIDTH)
    ) u_qualifier (
        .clock  (clock_out),
        .reset  (reset),
        .locked (clock_locked),
        .count  (lock_count)
    );

`ifdef DUMMY_DCM_DIFF_INPUT_HEARTBEAT_EN
    logic [HEARTBEAT_WIDTH-1:0] heartbeat_count;

    // free-running LED divider, independent of lock state
    always_ff @(posedge clock_out) begin
        heartbeat_count <= !reset ? '0 : heartbeat_count + 1'b1;
    end
    assign heartbeat = heartbeat_count[HEARTBEAT_BIT];
`endif

endmodule

// File: tb/tb_dummy_dcm_diff_input.sv
// tb_dummy_dcm_diff_input: directed table-driven bench for the DCM stand-in
module tb_dummy_dcm_diff_input;

    localparam int W = 4;

    logic         clock_p = 1'b0;
    logic         clock_n = 1'b1;
    logic         reset   = 1'b0;
    logic         clock_out;
    logic         clock_locked;
    logic [W-1:0] lock_count;
`ifdef DUMMY_DCM_DIFF_INPUT_HEARTBEAT_EN
    logic         heartbeat;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic rst;
        int   cnt;
        logic lk;
    } vec_t;

    vec_t vecs[$];

    dummy_dcm_diff_input #(
        .LOCK_COUNTER_WIDTH(W),
        .PERIOD(10.0),
        .HEARTBEAT_BIT(3)
    ) dut (
        .clock_p      (clock_p),
        .clock_n      (clock_n),
        .reset        (reset),
        .clock_out    (clock_out),
`ifdef DUMMY_DCM_DIFF_INPUT_HEARTBEAT_EN
        .heartbeat    (heartbeat),
`endif
        .clock_locked (clock_locked),
        .lock_count   (lock_count)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // one full 10 ns differential cycle; clock_out must track clock_p in both phases
    task automatic tick();
        clock_p = 1'b1;
        clock_n = 1'b0;
        #1 check("clock_out_high", int'(clock_out), 1);
        #4;
        clock_p = 1'b0;
        clock_n = 1'b1;
        #1 check("clock_out_low", int'(clock_out), 0);
        #4;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 0, 1'b0});
        for (int i = 1; i <= 20; i++) vecs.push_back('{1'b1, (i < 15) ? i : 15, i >= 16});
        for (int i = 0; i < 100; i++) vecs.push_back('{1'b1, 15, 1'b1});
        vecs.push_back('{1'b0, 0, 1'b0});
        for (int i = 1; i <= 16; i++) vecs.push_back('{1'b1, (i < 15) ? i : 15, i >= 16});

        #5;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            tick();
            check($sformatf("lock_count[%0d]", i), int'(lock_count), vecs[i].cnt);
            check($sformatf("clock_locked[%0d]", i), int'(clock_locked), int'(vecs[i].lk));
        end

        // stall the input with equal legs while high: output holds, counter frozen
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("stall_pre_count", int'(lock_count), 3);
        clock_p = 1'b1;
        clock_n = 1'b0;
        #1 check("stall_edge_count", int'(lock_count), 4);
        clock_p = 1'b0;
        #50;
        check("stall_hold_clock", int'(clock_out), 1);
        check("stall_hold_count", int'(lock_count), 4);
        clock_n = 1'b1;
        #1 check("stall_resume_low", int'(clock_out), 0);
        #4;
        tick();
        check("stall_resume_count", int'(lock_count), 5);
        check("stall_locked", int'(clock_locked), 0);

`ifdef DUMMY_DCM_DIFF_INPUT_HEARTBEAT_EN
        reset = 1'b0;
        tick();
        check("heartbeat_reset", int'(heartbeat), 0);
        reset = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            check($sformatf("heartbeat[%0d]", n), int'(heartbeat), (n >> 3) & 1);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
